alu_issue_stage: RTL and testbench

//   Operand/issue stage directly upstream of alu_32bit. Accepts one MIPS instruction per handshake.

---
 rtl/alu_issue_stage.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand/issue stage feeding an external alu_32bit.
// Decodes one MIPS instruction per accept and reads operands from a 32-entry
// register file, with a bypass from the result that is retiring in the same cycle.
// It drives registered ALU controls and writes the ALU result back.
// SLT needs two ALU passes: a SUB to find the sign, then a pass that selects alu_less.
`timescale 1ns/1ps

module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_binv,
    output logic [WIDTH-1:0] alu_less,
    output logic             alu_sel1,
    output logic             alu_sel0,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    output logic [4:0]       done_rd,
    output logic [WIDTH-1:0] done_data,
    output logic             err,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SLT1 = 2'd2, SLT2 = 2'd3} state_t;

    state_t           state;
    logic [WIDTH-1:0] rf [NREG];
    logic [4:0]       dest;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             accept;
    logic             retiring;
    logic             dec_ok;
    logic             dec_slt;
    logic             dec_imm;
    logic [1:0]       dec_sel;
    logic             dec_binv;
    logic             dec_cin;
    logic [4:0]       dec_dest;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic             unused_shamt;

    // Signed less-than from a SUB result: the sign bit, corrected for overflow.
    function automatic logic slt_set(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        logic ovf;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return r[WIDTH-1] ^ ovf;
    endfunction

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];
    assign in_ready     = (state != SLT1);
    assign accept       = in_valid && in_ready;
    assign retiring     = (state == EXEC) || (state == SLT2);
    assign dbg_data     = (dbg_addr == 5'd0) ? {WIDTH{1'b0}} : rf[dbg_addr];

    // Decode opcode/funct into ALU controls, destination and operand-b source.
    always_comb begin
        dec_ok   = 1'b1;
        dec_slt  = 1'b0;
        dec_imm  = 1'b0;
        dec_sel  = 2'b10;
        dec_binv = 1'b0;
        dec_cin  = 1'b0;
        dec_dest = instr[15:11];
        if (op == 6'h08) begin
            dec_imm  = 1'b1;
            dec_dest = rt;
        end else if (op == 6'h00) begin
            case (funct)
                6'h24:   dec_sel = 2'b00;
                6'h25:   dec_sel = 2'b01;
                6'h20:   dec_sel = 2'b10;
                6'h22: begin
                    dec_binv = 1'b1;
                    dec_cin  = 1'b1;
                end
                6'h2A: begin
                    dec_slt  = 1'b1;
                    dec_binv = 1'b1;
                    dec_cin  = 1'b1;
                end
                default: dec_ok = 1'b0;
            endcase
        end else begin
            dec_ok = 1'b0;
        end
    end

    // Operand fetch; a result retiring this edge overrides the not-yet-written regfile entry.
    always_comb begin
        if (rs == 5'd0) begin
            opnd_a = {WIDTH{1'b0}};
        end else if (retiring && (dest != 5'd0) && (rs == dest)) begin
            opnd_a = alu_result;
        end else begin
            opnd_a = rf[rs];
        end
        if (dec_imm) begin
            opnd_b = {{(WIDTH-16){instr[15]}}, instr[15:0]};
        end else if (rt == 5'd0) begin
            opnd_b = {WIDTH{1'b0}};
        end else if (retiring && (dest != 5'd0) && (rt == dest)) begin
            opnd_b = alu_result;
        end else begin
            opnd_b = rf[rt];
        end
    end

    // Issue FSM, ALU control registers, write-back and retire/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dest      <= 5'd0;
            alu_a     <= {WIDTH{1'b0}};
            alu_b     <= {WIDTH{1'b0}};
            alu_cin   <= 1'b0;
            alu_binv  <= 1'b0;
            alu_less  <= {WIDTH{1'b0}};
            alu_sel1  <= 1'b0;
            alu_sel0  <= 1'b0;
            done      <= 1'b0;
            done_rd   <= 5'd0;
            done_data <= {WIDTH{1'b0}};
            err       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= {WIDTH{1'b0}};
            end
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            alu_less <= {WIDTH{1'b0}};
            case (state)
                IDLE: state <= IDLE;
                EXEC, SLT2: begin
                    done      <= 1'b1;
                    done_rd   <= dest;
                    done_data <= alu_result;
                    if (dest != 5'd0) begin
                        rf[dest] <= alu_result;
                    end
                    state <= IDLE;
                end
                SLT1: begin
                    alu_less <= {{(WIDTH-1){1'b0}}, slt_set(alu_a, alu_b, alu_result)};
                    alu_sel1 <= 1'b1;
                    alu_sel0 <= 1'b1;
                    alu_binv <= 1'b1;
                    alu_cin  <= 1'b1;
                    state    <= SLT2;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                if (dec_ok) begin
                    alu_a    <= opnd_a;
                    alu_b    <= opnd_b;
                    alu_sel1 <= dec_sel[1];
                    alu_sel0 <= dec_sel[0];
                    alu_binv <= dec_binv;
                    alu_cin  <= dec_cin;
                    dest     <= dec_dest;
                    state    <= dec_slt ? SLT1 : EXEC;
                end else begin
                    err   <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models alu_32bit, scoreboards retire/err pulses
// against an architectural register-file model, and checks regfile contents via dbg.
`timescale 1ns/1ps

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] alu_a, alu_b, alu_less, alu_result, done_data, dbg_data;
    logic        alu_cin, alu_binv, alu_sel1, alu_sel0, done, err;
    logic [4:0]  done_rd;
    logic [4:0]  dbg_addr = 5'd0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        bit          drain;
        logic [4:0]  chk_reg;
        logic [31:0] chk_val;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vt[$];
    logic [31:0] ref_rf [32];
    logic [31:0] bb;

    alu_issue_stage #(.WIDTH(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_binv(alu_binv),
        .alu_less(alu_less), .alu_sel1(alu_sel1), .alu_sel0(alu_sel0),
        .alu_result(alu_result), .done(done), .done_rd(done_rd), .done_data(done_data),
        .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural alu_32bit.
    always_comb begin
        bb = alu_binv ? ~alu_b : alu_b;
        case ({alu_sel1, alu_sel0})
            2'b00:   alu_result = alu_a & bb;
            2'b01:   alu_result = alu_a | bb;
            2'b10:   alu_result = alu_a + bb + {31'd0, alu_cin};
            default: alu_result = alu_less;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction

    // Architectural reference: executes in program order on ref_rf.
    task automatic model(input logic [31:0] ins, output exp_t e);
        logic [31:0] a, b, v;
        logic [4:0]  d;
        a = ref_rf[ins[25:21]];
        b = ref_rf[ins[20:16]];
        v = 32'h0;
        d = ins[15:11];
        e.is_err = 1'b0;
        if (ins[31:26] == 6'h08) begin
            v = a + {{16{ins[15]}}, ins[15:0]};
            d = ins[20:16];
        end else if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h24:   v = a & b;
                6'h25:   v = a | b;
                6'h20:   v = a + b;
                6'h22:   v = a - b;
                6'h2A:   v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: e.is_err = 1'b1;
            endcase
        end else begin
            e.is_err = 1'b1;
        end
        e.rd   = e.is_err ? 5'd0 : d;
        e.data = e.is_err ? 32'h0 : v;
        if (!e.is_err && d != 5'd0) ref_rf[d] = v;
    endtask

    task automatic send(input logic [31:0] ins);
        int   w;
        exp_t e;
        @(negedge clk);
        instr    = ins;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        model(ins, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] v);
        dbg_addr = r;
        #1;
        chk(name, dbg_data, v);
    endtask

    // Scoreboard: retire pulses first (older), then error pulses.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_vs_err", {31'd0, e.is_err}, 32'd0);
                    chk("done_rd", {27'd0, done_rd}, {27'd0, e.rd});
                    chk("done_data", done_data, e.data);
                end
            end
            if (err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_err", {31'd0, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err_expected", {31'd0, e.is_err}, 32'd1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int          k;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_ctl", {27'd0, alu_cin, alu_binv, alu_sel1, alu_sel0, done}, 32'h0);
        chk("rst_less", alu_less, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk_reg("rst_dbg_r1", 5'd1, 32'h0);

        // Directed table
        vt.push_back('{addi(5'd1, 5'd0, 16'd1), 1'b1, 5'd1, 32'd1});
        vt.push_back('{addi(5'd2, 5'd0, 16'd3), 1'b1, 5'd2, 32'd3});
        vt.push_back('{addi(5'd4, 5'd0, 16'h5555), 1'b1, 5'd4, 32'h5555});
        for (int j = 1; j <= 16; j++)
            vt.push_back('{rtype(6'h20, 5'd4, 5'd4, 5'd4), (j == 16), 5'd4, 32'h5555 << j});
        vt.push_back('{addi(5'd4, 5'd4, 16'h5555), 1'b1, 5'd4, 32'h55555555});
        vt.push_back('{rtype(6'h20, 5'd3, 5'd4, 5'd4), 1'b1, 5'd3, 32'hAAAAAAAA});
        vt.push_back('{rtype(6'h24, 5'd5, 5'd3, 5'd4), 1'b1, 5'd5, 32'h0});
        vt.push_back('{rtype(6'h25, 5'd6, 5'd3, 5'd4), 1'b1, 5'd6, 32'hFFFFFFFF});
        vt.push_back('{rtype(6'h20, 5'd7, 5'd3, 5'd4), 1'b1, 5'd7, 32'hFFFFFFFF});
        vt.push_back('{rtype(6'h20, 5'd8, 5'd1, 5'd2), 1'b0, 5'd8, 32'd4});
        vt.push_back('{rtype(6'h22, 5'd9, 5'd8, 5'd1), 1'b1, 5'd9, 32'd3});
        vt.push_back('{rtype(6'h2A, 5'd10, 5'd4, 5'd3), 1'b1, 5'd10, 32'd0});
        vt.push_back('{rtype(6'h2A, 5'd11, 5'd3, 5'd4), 1'b1, 5'd11, 32'd1});
        vt.push_back('{rtype(6'h20, 5'd0, 5'd1, 5'd2), 1'b1, 5'd0, 32'd0});
        vt.push_back('{rtype(6'h3F, 5'd12, 5'd1, 5'd2), 1'b1, 5'd12, 32'd0});
        vt.push_back('{addi(5'd13, 5'd1, 16'hFFFF), 1'b1, 5'd13, 32'd0});
        foreach (vt[i]) begin
            send(vt[i].ins);
            if (vt[i].drain) begin
                drain();
                chk_reg($sformatf("vec%0d_r%0d", i, vt[i].chk_reg), vt[i].chk_reg, vt[i].chk_val);
            end
        end
        chk_reg("b2b_r8", 5'd8, 32'd4);

        // SLT two-pass sequence: stall, less select, 2-cycle latency
        send(rtype(6'h2A, 5'd14, 5'd3, 5'd4));
        chk("slt1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("slt1_ctl", {29'd0, alu_binv, alu_sel1, alu_sel0}, 32'd6);
        chk("slt1_less", alu_less, 32'd0);
        @(posedge clk);
        #1;
        chk("slt2_in_ready", {31'd0, in_ready}, 32'd1);
        chk("slt2_less", alu_less, 32'd1);
        chk("slt2_sel", {30'd0, alu_sel1, alu_sel0}, 32'd3);
        @(posedge clk);
        #1;
        chk("slt_done", {31'd0, done}, 32'd1);
        chk("slt_after_less", alu_less, 32'd0);
        drain();
        chk_reg("slt_r14", 5'd14, 32'd1);

        // Reset in SLT1 aborts the op
        send(rtype(6'h2A, 5'd15, 5'd3, 5'd4));
        rst = 1'b1;
        #1;
        chk("abort_alu_a", alu_a, 32'h0);
        chk("abort_alu_b", alu_b, 32'h0);
        chk("abort_ctl", {27'd0, alu_cin, alu_binv, alu_sel1, alu_sel0, done}, 32'h0);
        chk_reg("abort_r3", 5'd3, 32'h0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk_reg("abort_r15", 5'd15, 32'h0);

        // Randomized traffic with heavy register reuse
        for (int r = 1; r < 8; r++) send(addi(r[4:0], 5'd0, 16'($urandom)));
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: ins = rtype(6'h24, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                1: ins = rtype(6'h25, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                2: ins = rtype(6'h20, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                3: ins = rtype(6'h22, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                4: ins = rtype(6'h2A, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                5: ins = addi(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                default: ins = ($urandom_range(0, 1) == 0) ?
                               rtype(6'h3F, 5'($urandom_range(0, 7)), 5'd1, 5'd2) :
                               {6'h23, 26'($urandom)};
            endcase
            send(ins);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        for (int r = 0; r < 32; r++) chk_reg($sformatf("rand_r%0d", r), r[4:0], ref_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
